// File: rtl/color_bbox_detect.sv
// Colour-window pixel classifier with per-frame bounding-box / pixel-count accumulation.
// Results are published at each vs_n falling edge; a 1-cycle-delayed mask stream is forwarded.
module color_bbox_detect #(
    parameter int unsigned H_ACT   = 800,
    parameter int unsigned V_ACT   = 600,
    parameter logic [4:0]  R_MIN   = 5'd24,
    parameter logic [5:0]  G_MAX   = 6'd20,
    parameter logic [4:0]  B_MAX   = 5'd12,
    parameter int unsigned MIN_PIX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_n,
    input  logic        clken,
    input  logic [15:0] rgb_in,
    output logic        mask_out,
    output logic        mask_de,
    output logic        mask_vs_n,
    output logic        bbox_valid,
    output logic        found,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic [19:0] pix_cnt
);

    localparam int unsigned CW = 10;
    localparam int unsigned NW = 20;

    localparam logic [CW-1:0] X_LAST  = CW'(H_ACT - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(V_ACT - 1);
    localparam logic [CW-1:0] POS_MAX = '1;
    localparam logic [NW-1:0] CNT_MAX = '1;
    localparam logic [NW-1:0] MIN_CNT = NW'(MIN_PIX);

    logic [CW-1:0] x_pos;
    logic [CW-1:0] y_pos;
    logic [CW-1:0] acc_xmin;
    logic [CW-1:0] acc_xmax;
    logic [CW-1:0] acc_ymin;
    logic [CW-1:0] acc_ymax;
    logic [NW-1:0] acc_cnt;
    logic          vs_q;

    logic accept_c;
    logic match_c;
    logic commit_c;
    logic found_c;

    always_comb begin
        accept_c = clken & vs_n;
        match_c  = accept_c
                 & (rgb_in[15:11] >= R_MIN)
                 & (rgb_in[10:5]  <= G_MAX)
                 & (rgb_in[4:0]   <= B_MAX);
        commit_c = vs_q & ~vs_n;
        found_c  = (acc_cnt >= MIN_CNT);
    end

    // Raster position of the pixel being accepted; rows beyond the last fold onto it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (!vs_n) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (accept_c) begin
            if (x_pos == X_LAST) begin
                x_pos <= '0;
                if (y_pos != Y_LAST) begin
                    y_pos <= y_pos + CW'(1);
                end
            end else begin
                x_pos <= x_pos + CW'(1);
            end
        end
    end

    // Per-frame accumulators; commit and match are mutually exclusive via vs_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_xmin <= POS_MAX;
            acc_xmax <= '0;
            acc_ymin <= POS_MAX;
            acc_ymax <= '0;
            acc_cnt  <= '0;
        end else if (commit_c) begin
            acc_xmin <= POS_MAX;
            acc_xmax <= '0;
            acc_ymin <= POS_MAX;
            acc_ymax <= '0;
            acc_cnt  <= '0;
        end else if (match_c) begin
            if (x_pos < acc_xmin) acc_xmin <= x_pos;
            if (x_pos > acc_xmax) acc_xmax <= x_pos;
            if (y_pos < acc_ymin) acc_ymin <= y_pos;
            if (y_pos > acc_ymax) acc_ymax <= y_pos;
            if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + NW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vs_n;
        end
    end

    // Committed results hold until the next frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbox_valid <= 1'b0;
            found      <= 1'b0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            pix_cnt    <= '0;
        end else begin
            bbox_valid <= commit_c;
            if (commit_c) begin
                found   <= found_c;
                x_min   <= found_c ? acc_xmin : '0;
                x_max   <= found_c ? acc_xmax : '0;
                y_min   <= found_c ? acc_ymin : '0;
                y_max   <= found_c ? acc_ymax : '0;
                pix_cnt <= acc_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_out  <= 1'b0;
            mask_de   <= 1'b0;
            mask_vs_n <= 1'b1;
        end else begin
            mask_out  <= match_c;
            mask_de   <= clken;
            mask_vs_n <= vs_n;
        end
    end

endmodule

// File: tb/tb_color_bbox_detect.sv
// Scoreboarded bench for color_bbox_detect: two instances (MIN_PIX=16 and MIN_PIX=1) share one
// 40x30 stimulus stream; a raster model predicts each committed frame result.
module tb_color_bbox_detect;

    localparam int H = 40;
    localparam int V = 30;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    typedef struct packed {
        logic        found;
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [19:0] cnt;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        vs_n;
    logic        clken;
    logic [15:0] rgb_in;

    logic        mask_out, mask_de, mask_vs_n, bbox_valid, found;
    logic [9:0]  x_min, x_max, y_min, y_max;
    logic [19:0] pix_cnt;

    logic        m1_mask_out, m1_mask_de, m1_mask_vs_n, m1_bbox_valid, m1_found;
    logic [9:0]  m1_x_min, m1_x_max, m1_y_min, m1_y_max;
    logic [19:0] m1_pix_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    res_t q_main[$];
    res_t q_m1[$];

    int mx, my, mxmin, mxmax, mymin, mymax, mcnt;

    color_bbox_detect #(.H_ACT(H), .V_ACT(V), .MIN_PIX(16)) dut (
        .clk(clk), .rst_n(rst_n), .vs_n(vs_n), .clken(clken), .rgb_in(rgb_in),
        .mask_out(mask_out), .mask_de(mask_de), .mask_vs_n(mask_vs_n),
        .bbox_valid(bbox_valid), .found(found),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .pix_cnt(pix_cnt)
    );

    color_bbox_detect #(.H_ACT(H), .V_ACT(V), .MIN_PIX(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .vs_n(vs_n), .clken(clken), .rgb_in(rgb_in),
        .mask_out(m1_mask_out), .mask_de(m1_mask_de), .mask_vs_n(m1_mask_vs_n),
        .bbox_valid(m1_bbox_valid), .found(m1_found),
        .x_min(m1_x_min), .x_max(m1_x_max), .y_min(m1_y_min), .y_max(m1_y_max),
        .pix_cnt(m1_pix_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic is_match(input logic [15:0] c);
        return (c[15:11] >= 5'd24) && (c[10:5] <= 6'd20) && (c[4:0] <= 5'd12);
    endfunction

    function automatic void model_clear();
        mx = 0; my = 0;
        mxmin = 1023; mxmax = 0; mymin = 1023; mymax = 0; mcnt = 0;
    endfunction

    function automatic void model_pix(input logic [15:0] c);
        if (is_match(c)) begin
            if (mx < mxmin) mxmin = mx;
            if (mx > mxmax) mxmax = mx;
            if (my < mymin) mymin = my;
            if (my > mymax) mymax = my;
            if (mcnt < 20'hFFFFF) mcnt++;
        end
        if (mx == H - 1) begin
            mx = 0;
            if (my < V - 1) my++;
        end else begin
            mx++;
        end
    endfunction

    function automatic res_t mk_exp(input int minp);
        res_t r;
        r.found = (mcnt >= minp);
        r.xmin  = r.found ? 10'(mxmin) : 10'd0;
        r.xmax  = r.found ? 10'(mxmax) : 10'd0;
        r.ymin  = r.found ? 10'(mymin) : 10'd0;
        r.ymax  = r.found ? 10'(mymax) : 10'd0;
        r.cnt   = 20'(mcnt);
        return r;
    endfunction

    task automatic pix(input logic [15:0] c);
        @(negedge clk);
        vs_n = 1'b1; clken = 1'b1; rgb_in = c;
        model_pix(c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clken = 1'b0;
        end
    endtask

    // Frame boundary: vs_n low for 'hold' cycles with ignored red pixels strobed in; counts pulses.
    task automatic commit(input int hold, output int pulses);
        q_main.push_back(mk_exp(16));
        q_m1.push_back(mk_exp(1));
        @(negedge clk);
        vs_n = 1'b0; clken = 1'b1; rgb_in = RED;
        pulses = 0;
        for (int i = 0; i < hold + 2; i++) begin
            @(negedge clk);
            if (bbox_valid === 1'b1) pulses++;
            if (i == hold - 1) begin
                vs_n = 1'b1; clken = 1'b0; rgb_in = 16'h0;
            end
        end
        model_clear();
    endtask

    task automatic test_reset();
        int p;
        res_t e;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bbox_valid, found, x_min, x_max, y_min, y_max, pix_cnt, mask_out, mask_de} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got=%h exp=0",
                     {bbox_valid, found, x_min, x_max, y_min, y_max, pix_cnt, mask_out, mask_de});
        end
        n_tests++;
        if (mask_vs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mask_vs_n got=%b exp=1", mask_vs_n);
        end
        rst_n = 1'b1;
        idle(2);
        commit(1, p);
        n_tests++;
        if (p != 1) begin n_fail++; $display("FAIL reset_first_commit pulses=%0d exp=1", p); end
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL reset_empty_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        e = q_m1.pop_front();
        n_tests++;
        if ({m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL reset_empty_m1 got=%h exp=%h",
                     {m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt}, e);
        end
    endtask

    task automatic test_single_pixel();
        int p;
        res_t e;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < H; x++)
                pix((x == 5 && y == 3) ? RED : BLUE);
        commit(1, p);
        n_tests++;
        if (p != 1) begin n_fail++; $display("FAIL single_pulse pulses=%0d exp=1", p); end
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL single_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        e = q_m1.pop_front();
        n_tests++;
        if ({m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL single_m1 got=%h exp=%h",
                     {m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt}, e);
        end
    endtask

    task automatic test_band_frame();
        int p;
        res_t e;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                pix((x >= 1 && x <= 15) ? RED : (x >= 16 && x <= 25) ? GREEN : BLUE);
                idle(1);
            end
        commit(1, p);
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL band_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        e = q_m1.pop_front();
        n_tests++;
        if ({m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL band_m1 got=%h exp=%h",
                     {m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt}, e);
        end
    endtask

    task automatic test_empty_hold();
        int p;
        res_t e;
        for (int i = 0; i < H * V; i++) pix(BLUE);
        commit(3, p);
        n_tests++;
        if (p != 1) begin n_fail++; $display("FAIL hold_single_pulse pulses=%0d exp=1", p); end
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL empty_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        e = q_m1.pop_front();
        n_tests++;
        if ({m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL empty_m1 got=%h exp=%h",
                     {m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt}, e);
        end
    endtask

    task automatic test_partial_frame();
        int p;
        res_t e;
        for (int y = 0; y < 11; y++)
            for (int x = 0; x < H; x++)
                pix((y < 10) ? RED : BLUE);
        commit(1, p);
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL partial_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        void'(q_m1.pop_front());
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < H; x++)
                pix((y >= 1 && x >= 2 && x <= 3) ? RED : GREEN);
        commit(1, p);
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL clean_next_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        e = q_m1.pop_front();
        n_tests++;
        if ({m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL clean_next_m1 got=%h exp=%h",
                     {m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt}, e);
        end
    endtask

    task automatic test_row_fold();
        int p;
        res_t e;
        for (int y = 0; y < V + 2; y++)
            for (int x = 0; x < H; x++)
                pix((x == 7) ? RED : BLUE);
        commit(1, p);
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL fold_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        void'(q_m1.pop_front());
    endtask

    task automatic test_reset_mid_frame();
        int p;
        res_t e;
        logic exp_m[$];
        logic [15:0] c;
        logic m;
        for (int i = 0; i < 5 * H; i++) pix(RED);
        @(negedge clk);
        rst_n = 1'b0; clken = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt, mask_vs_n} !== {61'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_outs got=%h exp=%h",
                     {found, x_min, x_max, y_min, y_max, pix_cnt, mask_vs_n}, {61'd0, 1'b1});
        end
        rst_n = 1'b1;
        model_clear();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < H; x++) begin
                c = (x < 4) ? RED : (x[0] ? GREEN : BLUE);
                @(negedge clk);
                if (exp_m.size() > 0) begin
                    m = exp_m.pop_front();
                    n_tests++;
                    if (mask_out !== m || mask_de !== 1'b1) begin
                        n_fail++;
                        $display("FAIL mask_lag y=%0d x=%0d got=%b/%b exp=%b/1", y, x, mask_out, mask_de, m);
                    end
                end
                vs_n = 1'b1; clken = 1'b1; rgb_in = c;
                exp_m.push_back(is_match(c));
                model_pix(c);
            end
        @(negedge clk);
        clken = 1'b0;
        m = exp_m.pop_front();
        n_tests++;
        if (mask_out !== m) begin
            n_fail++;
            $display("FAIL mask_last got=%b exp=%b", mask_out, m);
        end
        commit(1, p);
        n_tests++;
        if (p != 1) begin n_fail++; $display("FAIL midreset_pulse pulses=%0d exp=1", p); end
        e = q_main.pop_front();
        n_tests++;
        if ({found, x_min, x_max, y_min, y_max, pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL box4x4_main got=%h exp=%h", {found, x_min, x_max, y_min, y_max, pix_cnt}, e);
        end
        e = q_m1.pop_front();
        n_tests++;
        if ({m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt} !== e) begin
            n_fail++;
            $display("FAIL box4x4_m1 got=%h exp=%h",
                     {m1_found, m1_x_min, m1_x_max, m1_y_min, m1_y_max, m1_pix_cnt}, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; vs_n = 1'b1; clken = 1'b0; rgb_in = 16'h0;
        model_clear();
        test_reset();
        test_single_pixel();
        test_band_frame();
        test_empty_hold();
        test_partial_frame();
        test_row_fold();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
